// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Receive end of a serial link. Bits arrive on strobes (i_ser_valid) and are
// assembled into a WIDTH-bit word, MSB-first or LSB-first. The order is chosen
// by i_dir, which is latched at the frame start. Completed words sit in a
// one-entry output buffer with a valid/ready handshake. A frame restarted
// mid-word produces a one-cycle o_frame_err pulse. A completed word that
// cannot enter a full buffer is dropped and sets the sticky o_overrun flag.
module serial_word_receiver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ser_in,
  input  logic             i_ser_valid,
  input  logic             i_frame_start,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_word_out,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_frame_err,
  output logic             o_overrun,
  input  logic             i_clr_overrun
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Shift one bit into a word. Direction 0 enters at the LSB end, so the first
  // bit ends up at the MSB. Direction 1 enters at the MSB end, so the first bit
  // ends up at the LSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                input logic             bit_in,
                                                input logic             dir_lsb);
    logic [WIDTH-1:0] res;
    if (dir_lsb) begin
      res = {bit_in, base[WIDTH-1:1]};
    end else begin
      res = {base[WIDTH-2:0], bit_in};
    end
    return res;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic             r_dir_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_start;
  logic             w_abort;
  logic             w_last;
  logic             w_dir;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_consume;
  logic             w_load;
  logic             w_drop;

  // Decode the current strobe. Also form the shifted word, and derive the
  // completion, load and drop conditions.
  always_comb begin
    w_start   = i_ser_valid & i_frame_start;
    w_abort   = w_start & (r_state == ST_SHIFT);
    w_last    = i_ser_valid & ~i_frame_start & (r_state == ST_SHIFT) &
                (r_cnt == CNT_W'(WIDTH - 1));
    // A frame start begins from a clean register and uses the fresh direction.
    if (w_start) begin
      w_dir  = i_dir;
      w_base = {WIDTH{1'b0}};
    end else begin
      w_dir  = r_dir_q;
      w_base = r_sr;
    end
    w_sr_next = shift_in(w_base, i_ser_in, w_dir);
    w_consume = r_valid & i_word_ready;
    // The buffer accepts a new word when it is empty or is emptied on this edge.
    w_load    = w_last & (~r_valid | i_word_ready);
    w_drop    = w_last & r_valid & ~i_word_ready;
  end

  // Frame assembly FSM: tracks IDLE/SHIFT, the shift register, the latched
  // direction, the bit count and the abort pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= {WIDTH{1'b0}};
      r_dir_q     <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      case (r_state)
        ST_IDLE: begin
          // A bit strobed without frame_start is dropped here.
          if (w_start) begin
            r_sr    <= w_sr_next;
            r_dir_q <= i_dir;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_start) begin
            // Restart: the partial word is discarded, and this bit is bit 1.
            r_sr    <= w_sr_next;
            r_dir_q <= i_dir;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_SHIFT;
          end else if (w_last) begin
            r_sr    <= w_sr_next;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_IDLE;
          end else if (i_ser_valid) begin
            r_sr    <= w_sr_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // One-entry output buffer: load the completed word, or release it on handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word  <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_word  <= w_sr_next;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Sticky overrun flag. When a drop and a clear coincide, the drop wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign o_word_out   = r_word;
  assign o_word_valid = r_valid;
  assign o_busy       = (r_state == ST_SHIFT);
  assign o_bit_cnt    = r_cnt;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule
